// File: rtl/scan_mem_reader.sv
// Issues SRAM reads for the scan address stream and buffers returned words in a
// credit-protected FIFO with frame-end marking. Optional: SCAN_MEM_READER_BOUNDS_CHECK_EN.
module scan_mem_reader #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1,
  parameter int DEPTH   = 4
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
  ,
  parameter int MEM_WORDS = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              addr_valid,
  output logic              addr_ready,
  input  logic [15:0]       frame_len,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              data_last
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
  ,
  output logic              oob_err,
  output logic              oob_word
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
  logic [MEM_LAT-1:0] vld_q, vld_d;
  logic [15:0]        beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]  fifo_mem_q [DEPTH];

  logic [CNT_W-1:0]   credits;
  logic [15:0]        frame_last;
  logic [DATA_W-1:0]  push_data;
  logic               accept, push, pop, oob_acc, tap_oob;

  // Every issued read owns a FIFO slot until it is popped, so the FIFO can never overflow.
  always_comb begin
    credits = fifo_count_q;
    for (int i = 0; i < MEM_LAT; i++) credits = credits + CNT_W'(vld_q[i]);
  end

  assign addr_ready = (credits < DEPTH_C) & ~flush & rst_n;
  assign accept     = addr_valid & addr_ready;
  assign mem_en     = accept & ~oob_acc;
  assign mem_addr   = mem_en ? addr_in : '0;

  assign push       = vld_q[MEM_LAT-1] & ~flush;
  assign data_valid = (fifo_count_q != '0);
  assign pop        = data_valid & data_ready & ~flush;
  assign data_out   = data_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign push_data  = tap_oob ? '0 : mem_rdata;

  assign frame_last = frame_len - 16'd1;
  assign data_last  = data_valid & (frame_len != 16'd0) & (beat_cnt_q == frame_last);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    vld_d        = vld_q << 1;
    vld_d[0]     = accept;
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    beat_cnt_d   = beat_cnt_q;
    if (frame_len == 16'd0) begin
      beat_cnt_d = '0;
    end else if (pop) begin
      beat_cnt_d = (data_last || (beat_cnt_q >= frame_last)) ? '0 : beat_cnt_q + 16'd1;
    end
    if (flush) begin
      vld_d        = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
      beat_cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      vld_q        <= '0;
      beat_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      vld_q        <= vld_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // NOTE: FIFO storage is not reset; the count gates data_out, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_data;
  end

`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] MEM_WORDS_C = AW1'(MEM_WORDS);

  logic [MEM_LAT-1:0] oob_pipe_q, oob_pipe_d;
  logic               oob_err_q, oob_err_d;
  logic [DEPTH-1:0]   oob_mem_q;

  // Out-of-range addresses still take a slot but never strobe the SRAM.
  assign oob_acc = accept & ({1'b0, addr_in} >= MEM_WORDS_C);
  assign tap_oob = oob_pipe_q[MEM_LAT-1];

  always_comb begin
    oob_pipe_d    = oob_pipe_q << 1;
    oob_pipe_d[0] = oob_acc;
    oob_err_d     = oob_err_q | oob_acc;
    if (flush) begin
      oob_pipe_d = '0;
      oob_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_pipe_q <= '0;
      oob_err_q  <= 1'b0;
    end else begin
      oob_pipe_q <= oob_pipe_d;
      oob_err_q  <= oob_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) oob_mem_q[wr_ptr_q] <= tap_oob;
  end

  assign oob_err  = oob_err_q;
  assign oob_word = data_valid & oob_mem_q[rd_ptr_q];
`else
  assign oob_acc = 1'b0;
  assign tap_oob = 1'b0;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifo_count_q == DEPTH_C)));

endmodule

// File: tb/tb_scan_mem_reader.sv
// Self-checking bench for scan_mem_reader: randomized and directed stimulus against a
// queue-based reference model; a second instance with MEM_LAT=3 covers flush of in-flight reads.
`timescale 1ns/1ps
module tb_scan_mem_reader;

  localparam int LAT_A     = 1;
  localparam int LAT_B     = 3;
  localparam int DEPTH     = 4;
  localparam int MEM_WORDS = 16;
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
  localparam logic [15:0] AMASK = 16'h000F;
`else
  localparam logic [15:0] AMASK = 16'hFFFF;
`endif

  logic clk;
  logic rst_n;

  logic        flush, addr_valid, addr_ready, mem_en, data_valid, data_ready, data_last;
  logic [15:0] addr_in, frame_len, mem_addr, mem_rdata, data_out;
  logic        b_flush, b_addr_valid, b_addr_ready, b_mem_en, b_data_valid, b_data_ready, b_data_last;
  logic [15:0] b_addr_in, b_frame_len, b_mem_addr, b_mem_rdata, b_data_out;
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
  logic        oob_err, oob_word, b_oob_err, b_oob_word;
`endif

  scan_mem_reader #(
    .ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT_A), .DEPTH(DEPTH)
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
    , .MEM_WORDS(MEM_WORDS)
`endif
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .addr_in(addr_in), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .frame_len(frame_len), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready), .data_last(data_last)
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
    , .oob_err(oob_err), .oob_word(oob_word)
`endif
  );

  scan_mem_reader #(
    .ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT_B), .DEPTH(DEPTH)
  ) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .addr_in(b_addr_in), .addr_valid(b_addr_valid), .addr_ready(b_addr_ready),
    .frame_len(b_frame_len), .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
    .data_out(b_data_out), .data_valid(b_data_valid), .data_ready(b_data_ready), .data_last(b_data_last)
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
    , .oob_err(b_oob_err), .oob_word(b_oob_word)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: data is address + 0x100, returned LAT cycles after the strobe.
  logic [15:0] a_hist [LAT_A];
  logic [15:0] b_hist [LAT_B];
  always @(posedge clk) begin
    a_hist[0] <= mem_addr;
    for (int i = 1; i < LAT_A; i++) a_hist[i] <= a_hist[i-1];
    b_hist[0] <= b_mem_addr;
    for (int i = 1; i < LAT_B; i++) b_hist[i] <= b_hist[i-1];
  end
  assign mem_rdata   = a_hist[LAT_A-1] + 16'h0100;
  assign b_mem_rdata = b_hist[LAT_B-1] + 16'h0100;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic        exp_oob_q[$];
  int          beats;
  logic        model_oob_err;
  logic        obs_acc, obs_pop, obs_last, obs_valid;
  logic        prev_flush, hold_pend;
  logic [15:0] hold_data;

  function automatic logic is_oob(input logic [15:0] a);
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
    return int'(a) >= MEM_WORDS;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return is_oob(a) ? 16'h0000 : a + 16'h0100;
  endfunction

  function automatic logic [15:0] rand_addr();
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
    return 16'($urandom_range(0, 19));
`else
    return 16'($urandom);
`endif
  endfunction

  task automatic clear_model();
    exp_q.delete();
    exp_oob_q.delete();
    beats         = 0;
    model_oob_err = 1'b0;
    prev_flush    = 1'b0;
    hold_pend     = 1'b0;
  endtask

  // One clock of the main instance: inputs were applied at the preceding negedge.
  task automatic cycle();
    logic [15:0] exp_w;
    logic        exp_o, exp_last;
    #1;
    obs_acc   = addr_valid && addr_ready;
    obs_valid = data_valid;
    obs_pop   = data_valid && data_ready && !flush;
    obs_last  = data_last;
    if (prev_flush) begin
      checks++;
      if (data_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_flush_valid: data_valid=%b expected 0", data_valid);
      end
    end
    if (hold_pend) begin
      checks++;
      if (data_valid !== 1'b1 || data_out !== hold_data) begin
        errors++;
        $display("FAIL hold_stable: valid=%b data=%h expected valid=1 data=%h", data_valid, data_out, hold_data);
      end
    end
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
    checks++;
    if (oob_err !== model_oob_err) begin
      errors++;
      $display("FAIL oob_err: got %b expected %b", oob_err, model_oob_err);
    end
`endif
    if (flush) begin
      checks++;
      if (addr_ready !== 1'b0 || mem_en !== 1'b0) begin
        errors++;
        $display("FAIL flush_gate: addr_ready=%b mem_en=%b expected 0 0", addr_ready, mem_en);
      end
      clear_model();
    end else begin
      if (obs_pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_word: data_out=%h with no outstanding word", data_out);
        end else begin
          exp_w    = exp_q.pop_front();
          exp_o    = exp_oob_q.pop_front();
          exp_last = (frame_len != 16'd0) && (beats == int'(frame_len) - 1);
          if (data_out !== exp_w || data_last !== exp_last) begin
            errors++;
            $display("FAIL pop_word: data=%h last=%b expected data=%h last=%b", data_out, data_last, exp_w, exp_last);
          end
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
          checks++;
          if (oob_word !== exp_o) begin
            errors++;
            $display("FAIL oob_word: got %b expected %b", oob_word, exp_o);
          end
`endif
          beats = (beats >= int'(frame_len) - 1) ? 0 : beats + 1;
        end
      end
      if (frame_len == 16'd0) beats = 0;
      checks++;
      if (obs_acc) begin
        if (mem_en !== !is_oob(addr_in) || (mem_en === 1'b1 && mem_addr !== addr_in)) begin
          errors++;
          $display("FAIL issue: mem_en=%b mem_addr=%h for addr %h", mem_en, mem_addr, addr_in);
        end
        exp_q.push_back(word_of(addr_in));
        exp_oob_q.push_back(is_oob(addr_in));
        if (is_oob(addr_in)) model_oob_err = 1'b1;
      end else if (mem_en !== 1'b0) begin
        errors++;
        $display("FAIL idle_mem_en: mem_en=%b expected 0", mem_en);
      end
    end
    prev_flush = flush;
    hold_pend  = data_valid && !data_ready && !flush;
    hold_data  = data_out;
    @(negedge clk);
  endtask

  task automatic drain();
    addr_valid = 1'b0;
    data_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) cycle();
    cycle();
    checks++;
    if (exp_q.size() != 0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: %0d words still expected, data_valid=%b", exp_q.size(), data_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; addr_valid = 1'b1; addr_in = 16'h0005;
    data_ready = 1'b1; frame_len = 16'd0;
    b_flush = 1'b0; b_addr_valid = 1'b0; b_addr_in = 16'h0; b_data_ready = 1'b0; b_frame_len = 16'd0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({addr_ready, mem_en, data_valid, data_last} !== 4'b0 || mem_addr !== 16'h0 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b en=%b addr=%h valid=%b last=%b data=%h expected all 0",
               addr_ready, mem_en, mem_addr, data_valid, data_last, data_out);
    end
    addr_valid = 1'b0;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (addr_ready !== 1'b1 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: addr_ready=%b data_valid=%b expected 1 0", addr_ready, data_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_streaming();
    logic [15:0] a;
    a = 16'h0;
    data_ready = 1'b1;
    frame_len  = 16'd0;
    for (int k = 0; k < 24; k++) begin
      addr_valid = (k < 20);
      addr_in    = a;
      cycle();
      if (obs_acc) a = (a + 16'd1) & AMASK;
      checks++;
      if (obs_acc !== (k < 20) || obs_valid !== (k >= 2 && k < 22)) begin
        errors++;
        $display("FAIL stream_timing: cycle %0d accept=%b valid=%b expected %b %b",
                 k, obs_acc, obs_valid, (k < 20), (k >= 2 && k < 22));
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] a;
    int          n_acc;
    a = 16'h0003; n_acc = 0;
    data_ready = 1'b0;
    addr_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      addr_in = a;
      cycle();
      if (obs_acc) begin
        n_acc++;
        a = (a + 16'd1) & AMASK;
      end
    end
    checks++;
    if (n_acc != DEPTH || addr_ready !== 1'b0 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_credits: accepts=%0d ready=%b valid=%b expected %0d 0 1",
               n_acc, addr_ready, data_valid, DEPTH);
    end
    data_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      addr_in = a;
      cycle();
      if (obs_acc) a = (a + 16'd1) & AMASK;
    end
    drain();
  endtask

  task automatic test_frame();
    logic [15:0] a;
    int          beat;
    a = 16'h0; beat = 0;
    frame_len  = 16'd6;
    data_ready = 1'b1;
    addr_valid = 1'b1;
    for (int k = 0; k < 60 && beat < 20; k++) begin
      addr_in = a;
      cycle();
      if (obs_acc) a = (a + 16'd1) & AMASK;
      if (obs_pop) begin
        beat++;
        checks++;
        if (obs_last !== (beat % 6 == 0)) begin
          errors++;
          $display("FAIL frame_last: beat %0d last=%b expected %b", beat, obs_last, (beat % 6 == 0));
        end
      end
    end
    frame_len = 16'd0;
    for (int k = 0; k < 12; k++) begin
      addr_in = a;
      cycle();
      if (obs_acc) a = (a + 16'd1) & AMASK;
      if (obs_pop) begin
        checks++;
        if (obs_last !== 1'b0) begin
          errors++;
          $display("FAIL frame_off: last=%b expected 0", obs_last);
        end
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      addr_valid = ($urandom_range(0, 3) != 0);
      addr_in    = rand_addr();
      data_ready = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 60) == 0) frame_len = 16'($urandom_range(0, 5));
      cycle();
    end
    flush = 1'b0;
    drain();
    frame_len = 16'd0;
  endtask

  task automatic test_flush_lat3();
    int lat;
    b_data_ready = 1'b0;
    b_addr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_addr_in = 16'h0010 + 16'(k);
      #1;
      checks++;
      if (b_addr_ready !== 1'b1 || b_mem_en !== 1'b1 || b_mem_addr !== b_addr_in) begin
        errors++;
        $display("FAIL lat3_fill: ready=%b en=%b addr=%h expected 1 1 %h", b_addr_ready, b_mem_en, b_mem_addr, b_addr_in);
      end
      @(negedge clk);
    end
    b_addr_valid = 1'b0;
    @(negedge clk);
    b_addr_valid = 1'b1;
    b_addr_in    = 16'h0077;
    b_flush      = 1'b1;
    #1;
    checks++;
    if (b_addr_ready !== 1'b0 || b_mem_en !== 1'b0 || b_data_valid !== 1'b1 || b_data_out !== 16'h0110) begin
      errors++;
      $display("FAIL lat3_flush_cycle: ready=%b en=%b valid=%b data=%h expected 0 0 1 0110",
               b_addr_ready, b_mem_en, b_data_valid, b_data_out);
    end
    @(negedge clk);
    b_flush      = 1'b0;
    b_addr_valid = 1'b0;
    b_data_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (b_data_valid !== 1'b0) begin
        errors++;
        $display("FAIL lat3_discard: cycle %0d after flush data_valid=%b data=%h expected valid 0", k, b_data_valid, b_data_out);
      end
      @(negedge clk);
    end
    b_addr_valid = 1'b1;
    b_addr_in    = 16'h0055;
    #1;
    checks++;
    if (b_addr_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat3_reaccept: addr_ready=%b expected 1", b_addr_ready);
    end
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      b_addr_valid = 1'b0;
      #1;
      if (b_data_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != LAT_B + 1 || b_data_out !== 16'h0155) begin
      errors++;
      $display("FAIL lat3_first_word: latency=%0d data=%h expected %0d 0155", lat, b_data_out, LAT_B + 1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (b_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat3_single: data_valid=%b expected 0", b_data_valid);
    end
    @(negedge clk);
    b_data_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [15:0] a;
    a = 16'h0003;
    data_ready = 1'b1;
    addr_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      addr_in = a;
      cycle();
      if (obs_acc) a = (a + 16'd1) & AMASK;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({addr_ready, mem_en, data_valid, data_last} !== 4'b0 || mem_addr !== 16'h0 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b en=%b addr=%h valid=%b last=%b data=%h expected all 0",
               addr_ready, mem_en, mem_addr, data_valid, data_last, data_out);
    end
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
    checks++;
    if (oob_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_oob: oob_err=%b expected 0", oob_err);
    end
`endif
    clear_model();
    @(negedge clk);
    addr_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (addr_ready !== 1'b1 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_release: addr_ready=%b data_valid=%b expected 1 0", addr_ready, data_valid);
    end
    @(negedge clk);
    addr_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      addr_in = a;
      cycle();
      if (obs_acc) a = (a + 16'd1) & AMASK;
    end
    drain();
  endtask

`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
  task automatic test_bounds();
    flush = 1'b1;
    cycle();
    flush      = 1'b0;
    data_ready = 1'b1;
    addr_valid = 1'b1;
    addr_in    = 16'd20;
    cycle();
    checks++;
    if (obs_acc !== 1'b1) begin
      errors++;
      $display("FAIL bounds_accept: accept=%b expected 1", obs_acc);
    end
    addr_in = 16'd3;
    cycle();
    addr_valid = 1'b0;
    #1;
    checks++;
    if (oob_err !== 1'b1 || data_valid !== 1'b1 || data_out !== 16'h0 || oob_word !== 1'b1) begin
      errors++;
      $display("FAIL bounds_word: oob_err=%b valid=%b data=%h oob_word=%b expected 1 1 0000 1",
               oob_err, data_valid, data_out, oob_word);
    end
    for (int k = 0; k < 5; k++) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    checks++;
    if (oob_err !== 1'b0) begin
      errors++;
      $display("FAIL bounds_clear: oob_err=%b expected 0 after flush", oob_err);
    end
    drain();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_frame();
    test_flush_lat3();
    test_random();
`ifdef SCAN_MEM_READER_BOUNDS_CHECK_EN
    test_bounds();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_mem_reader.md
Name: scan_mem_reader

Overview:
- Stage directly downstream of the affine scan address generator.
- Takes the generated 16-bit address stream and issues reads to a synchronous on-chip SRAM with fixed read latency.
- Buffers returned words in a credit-protected FIFO and presents them on a valid/ready stream with a frame-end marker.
- Decouples the free-running address side from a back-pressuring consumer; never drops or duplicates a word.

Parameters:
- ADDR_W, 16, address width; matches generator output.
- DATA_W, 16, SRAM word width.
- MEM_LAT, 1, SRAM read latency in cycles; legal range 1..4.
- DEPTH, 4, output FIFO entries; power of two, must be >= MEM_LAT+1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO, in-flight reads and beat counter.
- addr_in  in  ADDR_W  address from scan generator.
- addr_valid  in  1  addr_in valid.
- addr_ready  out  1  block can accept addr_in this cycle.
- frame_len  in  16  beats per frame; 0 = no frame marking.
- mem_en  out  1  SRAM read strobe.
- mem_addr  out  ADDR_W  SRAM read address.
- mem_rdata  in  DATA_W  SRAM read data, valid MEM_LAT cycles after mem_en.
- data_out  out  DATA_W  FIFO head word.
- data_valid  out  1  FIFO non-empty.
- data_ready  in  1  consumer accepts data_out.
- data_last  out  1  data_out is the final beat of a frame.

Behaviour:
- Reset (rst_n low, async): FIFO empty, in-flight pipe cleared, beat_cnt=0. data_valid=0, data_last=0, data_out=0, mem_en=0, mem_addr=0, addr_ready=0. addr_ready rises in the first cycle after rst_n deasserts.
- credits = fifo_count + inflight_count, both registered.
- addr_ready = (credits < DEPTH) & ~flush & rst_n. It depends only on registered state, never on data_ready.
- accept = addr_valid & addr_ready.
  - mem_en = accept and mem_addr = addr_in, combinational in the same cycle.
  - A MEM_LAT-deep valid shift register tracks the read. When its tap fires, mem_rdata is written to the FIFO tail at that edge.
- Latency: accept in cycle 0 gives data_valid=1 in cycle MEM_LAT+1 if the FIFO was empty. Sustained throughput is 1 word/cycle while data_ready=1.
- pop = data_valid & data_ready. Push and pop in the same cycle are both honoured, and fifo_count is unchanged.
- Credit rule guarantees no overflow. A push into a full FIFO cannot occur; this is an assertion target.
- Ordering: strictly FIFO; words exit in accept order.
- Beat counter (16-bit): increments on pop.
  - data_last = data_valid & (frame_len != 0) & (beat_cnt == frame_len-1).
  - A pop with data_last asserted, or with beat_cnt >= frame_len-1, clears beat_cnt to 0.
  - If frame_len == 0, beat_cnt holds 0 and data_last stays 0.
  - frame_len is read live; a change mid-frame takes effect on the next compare.
- flush (synchronous, priority over push/pop/accept):
  - FIFO emptied, valid shift register cleared (returning reads discarded), beat_cnt=0.
  - addr_ready=0 and mem_en=0 during the flush cycle; data_valid=0 from the next cycle.
- Reset mid-operation: immediate return to reset state. Outstanding SRAM data is ignored.
- data_out and data_last are don't-care when data_valid=0, but must be held stable while data_valid=1 and data_ready=0.

Optional Feature:
- Macro SCAN_MEM_READER_BOUNDS_CHECK_EN.
- When defined:
  - Adds parameter MEM_WORDS (default 1024), output oob_err (1 bit, sticky), and output oob_word (1 bit, per beat, aligned with data_out).
  - An accepted addr_in >= MEM_WORDS is still accepted, but mem_en stays 0 for it.
  - Its FIFO entry carries DATA_W'0 with oob_word=1.
  - oob_err sets in the cycle after the bad accept and clears only on reset or flush.
- When undefined: no extra ports or parameter; every accepted address drives mem_en=1.

Test Plan:
- Streaming: MEM_LAT=1, DEPTH=4, data_ready=1, addresses 0,1,2,... with SRAM model rdata=addr+0x100. data_out = 0x100,0x101,... starting cycle 2, one per cycle, no gaps.
- Backpressure: data_ready=0 after reset, addr_valid=1. Exactly 4 accepts, then addr_ready=0. Raising data_ready releases 4 words in order, then streaming resumes with no loss or duplicates.
- Frame marking: frame_len=6, continuous flow. data_last high on beats 6,12,18. Set frame_len=0 mid-run; data_last stays 0.
- Flush: MEM_LAT=3 with 2 reads in flight and 2 words buffered, pulse flush. data_valid=0 next cycle, the in-flight words never appear, and the first post-flush address is the first word out.
- Async reset: assert rst_n low mid-stream between clock edges. All outputs go 0 immediately, and addr_ready returns 1 one cycle after release.
- Bounds (SCAN_MEM_READER_BOUNDS_CHECK_EN, MEM_WORDS=16): address 20 is accepted. mem_en=0 that cycle, the word is 0 with oob_word=1, and oob_err stays 1 until flush.
